// File: rtl/mod_bus_collector.sv
// Write-bus collector: gathers busW-wide write beats into one plaintxtL word
// (or a single zero-extended flags beat) and presents it to a downstream demux.
module mod_bus_collector #(
    parameter int nAddr     = 2,
    parameter int busW      = 32,
    parameter int plaintxtL = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [nAddr-1:0]     wr_addr,
    input  logic [busW-1:0]      wr_data,
    output logic                 wr_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [nAddr-1:0]     out_addr,
    output logic [plaintxtL-1:0] out_data,
    output logic                 err
);

    localparam int NBEATS = plaintxtL / busW;
    localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [nAddr-1:0] A_FLAGS = '0;
    localparam logic [nAddr-1:0] A_DATA  = nAddr'(1);

    typedef enum logic [1:0] {IDLE, COLLECT, PRESENT} state_t;

    state_t               r_state, w_state_nxt;
    logic [CW-1:0]        r_cnt, w_cnt_nxt;
    logic [plaintxtL-1:0] r_data, w_data_nxt;
    logic [nAddr-1:0]     r_addr, w_addr_nxt;
    logic                 r_err, w_err_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
            r_addr  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_data  <= w_data_nxt;
            r_addr  <= w_addr_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_data_nxt  = r_data;
        w_addr_nxt  = r_addr;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (wr_en) begin
                    if (wr_addr == A_FLAGS) begin
                        w_data_nxt              = '0;
                        w_data_nxt[busW-1:0]    = wr_data;
                        w_addr_nxt              = A_FLAGS;
                        w_cnt_nxt               = '0;
                        w_state_nxt             = PRESENT;
                    end else if (wr_addr == A_DATA) begin
                        // Upper beats are cleared so nothing stale survives a new word
                        w_data_nxt              = '0;
                        w_data_nxt[busW-1:0]    = wr_data;
                        w_addr_nxt              = A_DATA;
                        w_cnt_nxt               = CW'(1);
                        w_state_nxt             = COLLECT;
                    end else begin
                        w_err_nxt               = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (wr_en) begin
                    if (wr_addr == A_DATA) begin
                        w_data_nxt[int'(r_cnt)*busW +: busW] = wr_data;
                        if (r_cnt == CW'(NBEATS-1)) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = PRESENT;
                        end else begin
                            w_cnt_nxt   = r_cnt + CW'(1);
                        end
                    end else if (wr_addr == A_FLAGS) begin
                        // Partial word is abandoned; the flags beat still goes out
                        w_err_nxt               = 1'b1;
                        w_data_nxt              = '0;
                        w_data_nxt[busW-1:0]    = wr_data;
                        w_addr_nxt              = A_FLAGS;
                        w_cnt_nxt               = '0;
                        w_state_nxt             = PRESENT;
                    end else begin
                        w_err_nxt               = 1'b1;
                        w_cnt_nxt               = '0;
                        w_state_nxt             = IDLE;
                    end
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign wr_ready  = (r_state != PRESENT);
    assign out_valid = (r_state == PRESENT);
    assign out_addr  = r_addr;
    assign out_data  = r_data;
    assign err       = r_err;

endmodule

// File: tb/tb_mod_bus_collector.sv
// Directed bench for mod_bus_collector: cycle-by-cycle vector table plus a
// hand-written gapped transfer.
module tb_mod_bus_collector;

    logic         clk = 1'b0;
    logic         rst, wr_en, out_ready;
    logic [1:0]   wr_addr;
    logic [31:0]  wr_data;
    logic         wr_ready, out_valid, err;
    logic [1:0]   out_addr;
    logic [127:0] out_data;

    int n_pass = 0;
    int n_tot  = 0;

    mod_bus_collector dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         r, en;
        logic [1:0]   a;
        logic [31:0]  d;
        logic         ordy;
        logic         x_rdy, x_vld;
        logic [1:0]   x_addr;
        logic [127:0] x_data;
        logic         x_err;
        logic         cd;   // compare out_addr/out_data on this row
    } vec_t;

    vec_t tbl[$];

    localparam logic [127:0] D1 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] D2 = 128'h11111111_22222222_33333333_44444444;

    function automatic vec_t mk(logic r, logic en, logic [1:0] a, logic [31:0] d, logic ordy,
                                logic xr, logic xv, logic [1:0] xa, logic [127:0] xd,
                                logic xe, logic cd);
        vec_t v;
        v.r = r; v.en = en; v.a = a; v.d = d; v.ordy = ordy;
        v.x_rdy = xr; v.x_vld = xv; v.x_addr = xa; v.x_data = xd; v.x_err = xe; v.cd = cd;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [127:0] act, input logic [127:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
        else n_pass++;
    endtask

    task automatic cyc(input logic r, input logic en, input logic [1:0] a,
                       input logic [31:0] d, input logic ordy);
        rst = r; wr_en = en; wr_addr = a; wr_data = d; out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] beats[4];

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; out_ready = 1'b0;
        beats[0] = 32'h03020100; beats[1] = 32'h07060504;
        beats[2] = 32'h0B0A0908; beats[3] = 32'h0F0E0D0C;

        // reset
        tbl.push_back(mk(1,0,0,0,0,            1,0,0,0,0,1));
        // 4-beat data word, held 5 cycles, then consumed
        tbl.push_back(mk(0,1,1,32'h03020100,0, 1,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,32'h07060504,0, 1,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,32'h0B0A0908,0, 1,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,32'h0F0E0D0C,0, 0,1,1,D1,0,1));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0,0,0,0,0, 0,1,1,D1,0,1));
        tbl.push_back(mk(0,0,0,0,1,            1,0,0,0,0,0));
        // flags word
        tbl.push_back(mk(0,1,0,32'hA5,0,       0,1,0,128'hA5,0,1));
        tbl.push_back(mk(0,0,0,0,1,            1,0,0,0,0,0));
        // flags beat interrupting a partial data word
        tbl.push_back(mk(0,1,1,32'h11111111,0, 1,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,32'h22222222,0, 1,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,32'h5A,0,       0,1,0,128'h5A,1,1));
        tbl.push_back(mk(0,0,0,0,1,            1,0,0,0,0,0));
        // reserved address from IDLE
        tbl.push_back(mk(0,1,3,32'hFFFF,0,     1,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,            1,0,0,0,0,0));
        // reserved address mid-COLLECT returns to IDLE (following flags beat is legal)
        tbl.push_back(mk(0,1,1,32'h01,0,       1,0,0,0,0,0));
        tbl.push_back(mk(0,1,2,32'h02,0,       1,0,0,0,1,0));
        tbl.push_back(mk(0,1,0,32'h77,0,       0,1,0,128'h77,0,1));
        tbl.push_back(mk(0,0,0,0,1,            1,0,0,0,0,0));
        // write during PRESENT coinciding with out_ready is dropped, then re-sent
        tbl.push_back(mk(0,1,0,32'h11,0,       0,1,0,128'h11,0,1));
        tbl.push_back(mk(0,1,0,32'h22,1,       1,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,            1,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,32'h22,0,       0,1,0,128'h22,0,1));
        tbl.push_back(mk(0,1,1,32'h33,0,       0,1,0,128'h22,0,1));
        tbl.push_back(mk(0,0,0,0,1,            1,0,0,0,0,0));
        // reset after two data beats, then a clean transfer
        tbl.push_back(mk(0,1,1,32'hDEADBEEF,0, 1,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,32'hCAFEBABE,0, 1,0,0,0,0,0));
        tbl.push_back(mk(1,1,1,32'h12345678,0, 1,0,0,0,0,1));
        tbl.push_back(mk(0,1,1,32'h44444444,0, 1,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,32'h33333333,0, 1,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,32'h22222222,0, 1,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,32'h11111111,0, 0,1,1,D2,0,1));
        tbl.push_back(mk(0,0,0,0,1,            1,0,0,0,0,0));
        // reset while presenting drops the pending word
        tbl.push_back(mk(0,1,0,32'h99,0,       0,1,0,128'h99,0,1));
        tbl.push_back(mk(1,0,0,0,0,            1,0,0,0,0,1));

        foreach (tbl[i]) begin
            cyc(tbl[i].r, tbl[i].en, tbl[i].a, tbl[i].d, tbl[i].ordy);
            chk("wr_ready",  i, 128'(wr_ready),  128'(tbl[i].x_rdy));
            chk("out_valid", i, 128'(out_valid), 128'(tbl[i].x_vld));
            chk("err",       i, 128'(err),       128'(tbl[i].x_err));
            if (tbl[i].cd) begin
                chk("out_addr", i, 128'(out_addr), 128'(tbl[i].x_addr));
                chk("out_data", i, out_data, tbl[i].x_data);
            end
        end

        // gapped transfer: 3 idle cycles between beats, state held throughout
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 1, beats[i], 0);
            chk("gap_vld", 100+i, 128'(out_valid), 128'(i == 3));
            chk("gap_err", 100+i, 128'(err), 128'(0));
            for (int g = 0; g < 3; g++) begin
                cyc(0, 0, 0, 0, 0);
                chk("gap_idle_vld", 100+i, 128'(out_valid), 128'(i == 3));
                chk("gap_idle_err", 100+i, 128'(err), 128'(0));
            end
        end
        chk("gap_data", 200, out_data, D1);
        chk("gap_addr", 200, 128'(out_addr), 128'(1));
        cyc(0, 0, 0, 0, 1);
        chk("gap_clear", 201, 128'(out_valid), 128'(0));
        chk("gap_rdy",   201, 128'(wr_ready),  128'(1));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
